fan_speed_ctrl: RTL and testbench

Fan run-state controller paired with the fan timer block. It turns debounced speed and off button presses into a 4-state speed FSM (OFF, SPD1, SPD2, SPD3) and drives the fan PWM and the speed LEDs. It exports `state` (fan running) to the timer and consumes the timer's `timeout` flag, shutting the fan off when the armed timer expires.

---
 rtl/fan_speed_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_fan_speed_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_speed_ctrl.sv
// ----------------------------------------------------------------------------
// fan_speed_ctrl
//
// Fan run-state controller. Debounced speed/off buttons drive a four-state
// speed FSM (OFF, SPD1, SPD2, SPD3). The FSM selects the PWM duty for the fan
// and lights one speed LED. An expiry edge on the fan timer's `timeout` flag
// shuts the fan off.
//
// Parameters:
//   DB_CYCLES  clocks a button must hold a new level before it is accepted
//   PWM_DIV    clocks per PWM step (period = 100 steps)
//   DUTY1..3   duty in steps (0..100) for SPD1..SPD3
//
// Ports:
//   clk        system clock
//   reset_p    synchronous, active-high reset
//   btn_speed  raw asynchronous speed button, active high
//   btn_off    raw asynchronous off button, active high
//   timeout    fan timer flag: 1 = idle/running, 0 = armed timer expired
//   state      1 while the fan runs (FSM not OFF), feeds the timer
//   speed      0 = OFF, 1 = SPD1, 2 = SPD2, 3 = SPD3
//   fan_pwm    PWM drive to the fan
//   speed_led  one-hot speed indicator, 000 when OFF
// ----------------------------------------------------------------------------
module fan_speed_ctrl #(
    parameter int DB_CYCLES = 1_250_000,
    parameter int PWM_DIV   = 1250,
    parameter int DUTY1     = 30,
    parameter int DUTY2     = 60,
    parameter int DUTY3     = 90
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_speed,
    input  logic       btn_off,
    input  logic       timeout,
    output logic       state,
    output logic [1:0] speed,
    output logic       fan_pwm,
    output logic [2:0] speed_led
);

    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [6:0]       STEP_LAST = 7'd99;

    localparam logic [6:0] DUTY1_Q = 7'(DUTY1);
    localparam logic [6:0] DUTY2_Q = 7'(DUTY2);
    localparam logic [6:0] DUTY3_Q = 7'(DUTY3);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SPD1 = 2'd1,
        SPD2 = 2'd2,
        SPD3 = 2'd3
    } fan_state_t;

    function automatic logic [2:0] led_for(input fan_state_t s);
        case (s)
            SPD1:    led_for = 3'b001;
            SPD2:    led_for = 3'b010;
            SPD3:    led_for = 3'b100;
            default: led_for = 3'b000;
        endcase
    endfunction

    function automatic logic [6:0] duty_for(input fan_state_t s);
        case (s)
            SPD1:    duty_for = DUTY1_Q;
            SPD2:    duty_for = DUTY2_Q;
            SPD3:    duty_for = DUTY3_Q;
            default: duty_for = 7'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Button path: index 0 = speed, 1 = off. Both buttons share one block so
    // each register vector has a single driver.
    // ------------------------------------------------------------------------
    logic [1:0]      btn_raw;
    logic [1:0]      s1;
    logic [1:0]      s2;
    logic [1:0]      db;
    logic [1:0]      db_d;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;

    assign btn_raw = {btn_off, btn_speed};

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            db_d <= db;
            for (int i = 0; i < 2; i++) begin
                // The counter measures how long s2 has disagreed with the
                // accepted level; any agreement restarts the measurement.
                if (s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // One-cycle pulse on each accepted press; releases produce nothing.
    assign press = db & ~db_d;

    // ------------------------------------------------------------------------
    // Timeout edge detect. tmo_d resets to 1 so a timer already reporting 0
    // at reset is not mistaken for an expiry, and a level that stays low
    // after shutdown never re-fires.
    // ------------------------------------------------------------------------
    logic tmo_d;
    logic expiry;

    assign expiry = tmo_d & ~timeout;

    // ------------------------------------------------------------------------
    // Speed FSM with registered, decoded outputs.
    // ------------------------------------------------------------------------
    fan_state_t fsm_q;
    fan_state_t fsm_next;

    // NOTE: always_comb assigns a default before any branch so no path leaves
    // fsm_next unassigned, which would infer a latch.
    always_comb begin
        fsm_next = fsm_q;
        if (expiry || press[1]) begin
            fsm_next = OFF;
        end else if (press[0]) begin
            case (fsm_q)
                OFF:     fsm_next = SPD1;
                SPD1:    fsm_next = SPD2;
                SPD2:    fsm_next = SPD3;
                default: fsm_next = SPD1;   // SPD3 wraps to SPD1, never OFF
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            fsm_q     <= OFF;
            state     <= 1'b0;
            speed     <= 2'd0;
            speed_led <= 3'b000;
            tmo_d     <= 1'b1;
        end else begin
            fsm_q     <= fsm_next;
            state     <= (fsm_next != OFF);
            speed     <= fsm_next;
            speed_led <= led_for(fsm_next);
            tmo_d     <= timeout;
        end
    end

    // ------------------------------------------------------------------------
    // PWM: prescaler -> 100-step period. Duty is latched only at the period
    // boundary so each period runs at a single duty, but the running check on
    // fsm_q drops the output as soon as the FSM reaches OFF.
    // ------------------------------------------------------------------------
    logic [PRE_W-1:0] pre;
    logic [6:0]       step;
    logic [6:0]       duty_q;
    logic             pre_wrap;

    assign pre_wrap = (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            pre     <= '0;
            step    <= '0;
            duty_q  <= '0;
            fan_pwm <= 1'b0;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) begin
                step <= (step == STEP_LAST) ? 7'd0 : step + 7'd1;
                if (step == STEP_LAST) begin
                    duty_q <= duty_for(fsm_q);
                end
            end
            fan_pwm <= (step < duty_q) && (fsm_q != OFF);
        end
    end

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for fan_speed_ctrl (DB_CYCLES = 4, PWM_DIV = 2, default duties).
// A behavioural model predicts every output each cycle; a compare process
// checks the DUT against it on every falling edge. Directed scenarios add
// hand-computed literal checks, then a randomized phase exercises presses,
// glitches, expiry and resets.
// ----------------------------------------------------------------------------
module tb_fan_speed_ctrl;

    localparam int DB = 4;
    localparam int PD = 2;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       btn_speed;
    logic       btn_off;
    logic       timeout;
    logic       dut_state;
    logic [1:0] dut_speed;
    logic       dut_pwm;
    logic [2:0] dut_led;

    int total = 0;
    int bad   = 0;

    fan_speed_ctrl #(
        .DB_CYCLES(DB),
        .PWM_DIV  (PD),
        .DUTY1    (30),
        .DUTY2    (60),
        .DUTY3    (90)
    ) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .btn_speed(btn_speed),
        .btn_off  (btn_off),
        .timeout  (timeout),
        .state    (dut_state),
        .speed    (dut_speed),
        .fan_pwm  (dut_pwm),
        .speed_led(dut_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model. Debounce rule: the accepted level flips once the
    // synchronized input has shown the opposite level on DB consecutive
    // clocks. PWM position is derived arithmetically from the cycle count.
    // ------------------------------------------------------------------------
    int duty_tab [4] = '{0, 30, 60, 90};

    bit m_s1   [2];
    bit m_s2   [2];
    bit m_db   [2];
    bit m_rise [2];
    bit win    [2][DB];
    int m_speed;
    bit m_tmo;
    int m_cyc;
    int m_duty;
    bit m_pwm;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit raw [2];
        bit p_spd, p_off, expiry, all_opp;
        int pre, stp;
        raw[0] = btn_speed;
        raw[1] = btn_off;
        if (reset_p) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_rise[b] = 0;
                for (int i = 0; i < DB; i++) win[b][i] = 0;
            end
            m_speed = 0; m_tmo = 1; m_cyc = 0; m_duty = 0; m_pwm = 0;
            m_valid = 1;
        end else begin
            p_spd  = m_rise[0];
            p_off  = m_rise[1];
            expiry = m_tmo && !timeout;

            pre = m_cyc % PD;
            stp = (m_cyc / PD) % 100;
            m_pwm = (stp < m_duty) && (m_speed != 0);
            if (stp == 99 && pre == PD - 1) m_duty = duty_tab[m_speed];
            m_cyc++;

            if (expiry || p_off) m_speed = 0;
            else if (p_spd)      m_speed = (m_speed % 3) + 1;
            m_tmo = timeout;

            for (int b = 0; b < 2; b++) begin
                for (int i = DB - 1; i > 0; i--) win[b][i] = win[b][i-1];
                win[b][0] = m_s2[b];
                all_opp = 1;
                for (int i = 0; i < DB; i++) if (win[b][i] == m_db[b]) all_opp = 0;
                m_rise[b] = 0;
                if (all_opp) begin
                    m_db[b]   = !m_db[b];
                    m_rise[b] = m_db[b];
                    for (int i = 0; i < DB; i++) win[b][i] = m_db[b];
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("state", 32'(dut_state), 32'(m_speed != 0));
            check("speed", 32'(dut_speed), 32'(m_speed));
            check("speed_led", 32'(dut_led), (m_speed == 0) ? 32'd0 : (32'd1 << (m_speed - 1)));
            check("fan_pwm", 32'(dut_pwm), 32'(m_pwm));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------------
    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit spd, input bit off, input int len);
        btn_speed = spd;
        btn_off   = off;
        step_clk(len);
        btn_speed = 1'b0;
        btn_off   = 1'b0;
        step_clk(12);
    endtask

    task automatic count_pwm(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step_clk(1);
            highs += int'(dut_pwm);
        end
    endtask

    initial begin
        int highs;
        int r, len;
        reset_p   = 1'b1;
        btn_speed = 1'b0;
        btn_off   = 1'b0;
        timeout   = 1'b1;
        step_clk(3);
        check("rst_state", 32'(dut_state), 32'd0);
        check("rst_speed", 32'(dut_speed), 32'd0);
        check("rst_led", 32'(dut_led), 32'd0);
        check("rst_pwm", 32'(dut_pwm), 32'd0);
        reset_p = 1'b0;
        step_clk(2);

        // 1: held button -> one transition at N+6.
        btn_speed = 1'b1;
        step_clk(6);
        check("t1_before_n6", 32'(dut_speed), 32'd0);
        step_clk(1);
        check("t1_speed_n6", 32'(dut_speed), 32'd1);
        check("t1_state", 32'(dut_state), 32'd1);
        check("t1_led", 32'(dut_led), 32'b001);
        check("t1_model", 32'(m_speed), 32'd1);
        step_clk(3);
        btn_speed = 1'b0;
        step_clk(20);
        check("t1_single", 32'(dut_speed), 32'd1);

        // 2: back to OFF, then four presses.
        press(1'b0, 1'b1, 5);
        check("t2_off", 32'(dut_speed), 32'd0);
        press(1'b1, 1'b0, 5);
        check("t2_p1", 32'(dut_speed), 32'd1);
        press(1'b1, 1'b0, 5);
        check("t2_p2", 32'(dut_speed), 32'd2);
        press(1'b1, 1'b0, 5);
        check("t2_p3", 32'(dut_speed), 32'd3);
        press(1'b1, 1'b0, 5);
        check("t2_p4", 32'(dut_speed), 32'd1);

        // 3: glitches of 1..3 clocks are rejected, 5 clocks advances.
        for (int g = 1; g <= 3; g++) begin
            press(1'b1, 1'b0, g);
            check("t3_glitch", 32'(dut_speed), 32'd1);
        end
        press(1'b1, 1'b0, 5);
        check("t3_advance", 32'(dut_speed), 32'd2);

        // 4: PWM high time over a full period at SPD2, then SPD3.
        step_clk(250);
        count_pwm(200, highs);
        check("t4_spd2_highs", 32'(highs), 32'd120);
        press(1'b1, 1'b0, 5);
        check("t4_spd3", 32'(dut_speed), 32'd3);
        step_clk(210);
        count_pwm(200, highs);
        check("t4_spd3_highs", 32'(highs), 32'd180);

        // 5: expiry edge shuts down; persistent low does not block restart.
        timeout = 1'b0;
        step_clk(1);
        check("t5_off", 32'(dut_speed), 32'd0);
        check("t5_state", 32'(dut_state), 32'd0);
        step_clk(1);
        check("t5_pwm", 32'(dut_pwm), 32'd0);
        press(1'b1, 1'b0, 5);
        check("t5_restart", 32'(dut_speed), 32'd1);
        step_clk(30);
        check("t5_stays", 32'(dut_speed), 32'd1);
        timeout = 1'b1;
        step_clk(2);

        // 6: simultaneous off and speed press -> OFF; reset mid-debounce.
        press(1'b1, 1'b1, 5);
        check("t6_both", 32'(dut_speed), 32'd0);
        btn_speed = 1'b1;
        step_clk(3);
        reset_p   = 1'b1;
        btn_speed = 1'b0;
        step_clk(1);
        reset_p   = 1'b0;
        step_clk(15);
        check("t6_reset_press", 32'(dut_speed), 32'd0);

        // Randomized phase, checked by the model.
        for (int it = 0; it < 200; it++) begin
            r   = $urandom_range(0, 9);
            len = $urandom_range(1, 8);
            case (r)
                0, 1, 2, 3: begin btn_speed = 1'b1; step_clk(len); end
                4:          begin btn_off = 1'b1; step_clk(len); end
                5:          begin btn_speed = 1'b1; btn_off = 1'b1; step_clk(len); end
                6:          begin timeout = 1'b0; step_clk($urandom_range(1, 20)); end
                7:          begin reset_p = 1'b1; step_clk($urandom_range(1, 2)); end
                8:          step_clk($urandom_range(0, 300));
                default: begin
                    for (int k = 0; k < 10; k++) begin
                        btn_speed = 1'($urandom_range(0, 1));
                        btn_off   = 1'($urandom_range(0, 3) == 0);
                        step_clk(1);
                    end
                end
            endcase
            btn_speed = 1'b0;
            btn_off   = 1'b0;
            reset_p   = 1'b0;
            if ($urandom_range(0, 3) != 0) timeout = 1'b1;
            step_clk($urandom_range(0, 12));
        end
        step_clk(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
